fifo_push_arbiter: RTL

Round-robin multi-grant arbiter sharing the multi-lane push port of the team's multi-push/multi-pop FIFO among NR single-word requesters (UART RX channels, FFT result writers). Each cycle it grants up to min(can_push, NI) valid requesters, packs their words into consecutive push lanes and drives the FIFO push count. A registered round-robin pointer gives fairness across cycles.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_multi_grant_picker.sv | 43 ++++
 rtl/fifo_push_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared widths, requester index type and the modulo-NR wrap helper for the
// FIFO push arbiter.
package fifo_arb_pkg;

   localparam int ARB_NR     = 4;
   localparam int ARB_NI     = 2;
   localparam int ARB_PTR_W  = $clog2(ARB_NR);
   localparam int ARB_LANE_W = $clog2(ARB_NI + 1);

   typedef logic [ARB_PTR_W-1:0] req_idx_t;

   // Explicit wrap compare so NR need not be a power of two.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_multi_grant_picker.sv
// Combinational round-robin scan: picks the first min(valid, can_push, NI)
// requesters starting at rr_ptr and reports their lane order.
module rr_multi_grant_picker
   import fifo_arb_pkg::*;
#(
   parameter int NR = ARB_NR,
   parameter int NI = ARB_NI
) (
   input  logic [NR-1:0]                valid,
   input  logic [$clog2(NI+1)-1:0]      can_push,
   input  logic [$clog2(NR)-1:0]        rr_ptr,
   output logic [NR-1:0]                grant,
   output logic [$clog2(NI+1)-1:0]      g_cnt,
   output logic [NI*$clog2(NR)-1:0]     lane_src,
   output logic [$clog2(NR)-1:0]        last_idx
);

   localparam int PW = $clog2(NR);
   localparam int LW = $clog2(NI + 1);

   always_comb begin
      int idx;
      int g;
      int lim;
      grant    = '0;
      lane_src = '0;
      last_idx = rr_ptr;
      g        = 0;
      idx      = int'(rr_ptr);
      lim      = (int'(can_push) > NI) ? NI : int'(can_push);
      for (int k = 0; k < NR; k++) begin
         if (valid[PW'(idx)] && (g < lim)) begin
            grant[PW'(idx)]       = 1'b1;
            lane_src[g*PW +: PW]  = PW'(idx);
            last_idx              = PW'(idx);
            g                     = g + 1;
         end
         idx = wrap_inc(idx, NR);
      end
      g_cnt = LW'(g);
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin multi-grant arbiter for the multi-lane FIFO push port.
// Optional per-requester stall counters are built with FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int W  = 16,
   parameter int NR = ARB_NR,
   parameter int NI = ARB_NI
`ifdef FIFO_PUSH_ARB_STATS_EN
   ,parameter int CW = 16
`endif
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NR-1:0]            req_valid,
   input  logic [NR*W-1:0]          req_data,
   output logic [NR-1:0]            req_ready,
   input  logic [$clog2(NI+1)-1:0]  can_push,
   output logic [$clog2(NI+1)-1:0]  push,
   output logic [NI*W-1:0]          push_data
`ifdef FIFO_PUSH_ARB_STATS_EN
   ,output logic [NR*CW-1:0]        stall_cnt
`endif
);

   localparam int PW = $clog2(NR);
   localparam int LW = $clog2(NI + 1);

   logic [PW-1:0]    rr_ptr;
   logic [NR-1:0]    valid_gated;
   logic [NR-1:0]    grant;
   logic [LW-1:0]    g_cnt;
   logic [NI*PW-1:0] lane_src;
   logic [PW-1:0]    last_idx;

   // Gating valids with rstn keeps the reset cycle free of any push.
   assign valid_gated = rstn ? req_valid : '0;

   rr_multi_grant_picker #(.NR(NR), .NI(NI)) u_picker (
      .valid    (valid_gated),
      .can_push (can_push),
      .rr_ptr   (rr_ptr),
      .grant    (grant),
      .g_cnt    (g_cnt),
      .lane_src (lane_src),
      .last_idx (last_idx)
   );

   assign req_ready = grant;
   assign push      = g_cnt;

   always_comb begin
      push_data = '0;
      for (int k = 0; k < NI; k++) begin
         if (k < int'(g_cnt))
            push_data[k*W +: W] = req_data[int'(lane_src[k*PW +: PW])*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         rr_ptr <= '0;
      else if (g_cnt != '0)
         rr_ptr <= PW'(wrap_inc(int'(last_idx), NR));
   end

`ifdef FIFO_PUSH_ARB_STATS_EN
   for (genvar i = 0; i < NR; i++) begin : g_stats
      logic [CW-1:0] cnt;
      always_ff @(posedge clk) begin
         if (!rstn)
            cnt <= '0;
         else if (req_valid[i] && !req_ready[i] && (cnt != '1))
            cnt <= cnt + 1'b1;
      end
      assign stall_cnt[i*CW +: CW] = cnt;
   end
`endif

endmodule
